// File: rtl/instruction_memory_sync.sv
// Synchronous-read instruction memory with sequential program-load port and fault flags.
// Optional macro IMEM_PARITY_EN adds a stored even-parity bit per word and checks it on fetch.
module instruction_memory_sync #(
    parameter int unsigned           DATA_WIDTH    = 32,
    parameter int unsigned           ADDR_BITS     = 7,
    parameter bit                    LOAD_ON_RESET = 1'b0,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD      = '0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [31:0]           Address,
    input  logic                  ReadEn,
    input  logic                  Stall,
    input  logic                  LoadStart,
    input  logic                  LoadValid,
    input  logic                  LoadLast,
    input  logic [DATA_WIDTH-1:0] LoadData,
    output logic                  Ready,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic                  InstrValid,
    output logic                  AddrFault,
    output logic [ADDR_BITS:0]    LoadCount,
    output logic                  ParityErr
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] LAST_INDEX = (ADDR_BITS + 1)'(DEPTH - 1);

`ifdef IMEM_PARITY_EN
    localparam int unsigned ENTRY_WIDTH = DATA_WIDTH + 1;
    localparam logic [ENTRY_WIDTH-1:0] INIT_ENTRY = {^NOP_WORD, NOP_WORD};
`else
    localparam int unsigned ENTRY_WIDTH = DATA_WIDTH;
    localparam logic [ENTRY_WIDTH-1:0] INIT_ENTRY = NOP_WORD;
`endif

    typedef enum logic {StLoad, StRun} state_e;

    state_e                   state;
    logic [ENTRY_WIDTH-1:0]   mem [DEPTH] = '{default: INIT_ENTRY};

    logic [ADDR_BITS-1:0]     rd_index;
    logic                     rd_fault;
    logic [ENTRY_WIDTH-1:0]   rd_entry;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     rd_perr;

    logic                     wr_en;
    logic [ADDR_BITS-1:0]     wr_index;
    logic [ENTRY_WIDTH-1:0]   wr_entry;

    assign rd_index = Address[ADDR_BITS+1:2];
    assign rd_fault = (|Address[1:0]) | (|Address[31:ADDR_BITS+2]);
    assign rd_entry = mem[rd_index];
    assign rd_data  = rd_entry[DATA_WIDTH-1:0];

`ifdef IMEM_PARITY_EN
    // Stored bit makes the whole entry even; any odd total is a flipped bit.
    assign rd_perr  = ^rd_entry;
    assign wr_entry = {^LoadData, LoadData};
`else
    assign rd_perr  = 1'b0;
    assign wr_entry = LoadData;
`endif

    // LoadStart restarts the pointer, so a same-cycle write lands at index 0.
    assign wr_en    = (state == StLoad) && LoadValid && !Reset;
    assign wr_index = LoadStart ? '0 : LoadCount[ADDR_BITS-1:0];

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_index] <= wr_entry;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= LOAD_ON_RESET ? StLoad : StRun;
            Instruction <= NOP_WORD;
            InstrValid  <= 1'b0;
            AddrFault   <= 1'b0;
            ParityErr   <= 1'b0;
            LoadCount   <= '0;
        end else begin
            unique case (state)
                StLoad: begin
                    InstrValid <= 1'b0;
                    if (LoadStart) begin
                        LoadCount <= LoadValid ? (ADDR_BITS + 1)'(1) : '0;
                    end else if (LoadValid) begin
                        LoadCount <= LoadCount + 1'b1;
                        if (LoadLast || LoadCount == LAST_INDEX) begin
                            state <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (LoadStart) begin
                        state       <= StLoad;
                        LoadCount   <= '0;
                        Instruction <= NOP_WORD;
                        InstrValid  <= 1'b0;
                        AddrFault   <= 1'b0;
                        ParityErr   <= 1'b0;
                    end else if (!Stall) begin
                        if (ReadEn) begin
                            InstrValid  <= 1'b1;
                            AddrFault   <= rd_fault;
                            ParityErr   <= !rd_fault && rd_perr;
                            Instruction <= (rd_fault || rd_perr) ? NOP_WORD : rd_data;
                        end else begin
                            InstrValid <= 1'b0;
                            AddrFault  <= 1'b0;
                            ParityErr  <= 1'b0;
                        end
                    end
                end
                default: state <= StRun;
            endcase
        end
    end

    assign Ready = (state == StRun);

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Directed bench: one instance boots into LOAD, a second (sharing all inputs) boots into RUN.
// Define IMEM_PARITY_EN for both RTL and bench to exercise the parity checks.
module tb_instruction_memory_sync;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] Address = '0;
    logic        ReadEn = 1'b0;
    logic        Stall = 1'b0;
    logic        LoadStart = 1'b0;
    logic        LoadValid = 1'b0;
    logic        LoadLast = 1'b0;
    logic [31:0] LoadData = '0;

    logic        ready_a, valid_a, fault_a, perr_a;
    logic [31:0] instr_a;
    logic [7:0]  count_a;
    logic        ready_b, valid_b, fault_b, perr_b;
    logic [31:0] instr_b;
    logic [7:0]  count_b;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    instruction_memory_sync #(.LOAD_ON_RESET(1'b1)) dut (
        .Clk(Clk), .Reset(Reset), .Address(Address), .ReadEn(ReadEn), .Stall(Stall),
        .LoadStart(LoadStart), .LoadValid(LoadValid), .LoadLast(LoadLast),
        .LoadData(LoadData), .Ready(ready_a), .Instruction(instr_a), .InstrValid(valid_a),
        .AddrFault(fault_a), .LoadCount(count_a), .ParityErr(perr_a)
    );

    instruction_memory_sync #(.LOAD_ON_RESET(1'b0)) dut0 (
        .Clk(Clk), .Reset(Reset), .Address(Address), .ReadEn(ReadEn), .Stall(Stall),
        .LoadStart(LoadStart), .LoadValid(LoadValid), .LoadLast(LoadLast),
        .LoadData(LoadData), .Ready(ready_b), .Instruction(instr_b), .InstrValid(valid_b),
        .AddrFault(fault_b), .LoadCount(count_b), .ParityErr(perr_b)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] addr);
        Address = addr;
        ReadEn  = 1'b1;
        step();
        ReadEn  = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] data, input logic last);
        LoadValid = 1'b1;
        LoadData  = data;
        LoadLast  = last;
        step();
        LoadValid = 1'b0;
        LoadLast  = 1'b0;
    endtask

    logic [31:0] prog [4] = '{32'h3404_0000, 32'h0800_0004, 32'h2004_0A0A, 32'h8C90_0004};

    initial begin
        // Reset state
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("rst_ready_a", 32'(ready_a), 32'd0);
        check("rst_ready_b", 32'(ready_b), 32'd1);
        check("rst_instr", instr_a, NOP);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_fault", 32'(fault_a), 32'd0);
        check("rst_perr", 32'(perr_a), 32'd0);
        check("rst_count", 32'(count_a), 32'd0);

        // Four-word program, LoadLast on the fourth
        for (int i = 0; i < 4; i++) begin
            load_word(prog[i], i == 3);
            if (i == 2) check("load3_ready", 32'(ready_a), 32'd0);
        end
        check("load_done_ready", 32'(ready_a), 32'd1);
        check("load_done_count", 32'(count_a), 32'd4);
        fetch(32'h8);
        check("fetch8_instr", instr_a, 32'h2004_0A0A);
        check("fetch8_valid", 32'(valid_a), 32'd1);

        // Stall hold
        fetch(32'h4);
        check("fetch4_instr", instr_a, 32'h0800_0004);
        Stall   = 1'b1;
        ReadEn  = 1'b1;
        Address = 32'hC;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_instr", instr_a, 32'h0800_0004);
            check("stall_valid", 32'(valid_a), 32'd1);
        end
        Stall = 1'b0;
        step();
        ReadEn = 1'b0;
        check("unstall_instr", instr_a, 32'h8C90_0004);
        step();
        check("idle_valid", 32'(valid_a), 32'd0);
        check("idle_instr_hold", instr_a, 32'h8C90_0004);

        // Address faults
        fetch(32'h202);
        check("f202_fault", 32'(fault_a), 32'd1);
        check("f202_instr", instr_a, NOP);
        check("f202_valid", 32'(valid_a), 32'd1);
        fetch(32'h200);
        check("f200_fault", 32'(fault_a), 32'd1);
        fetch(32'h8000_0008);
        check("fhigh_fault", 32'(fault_a), 32'd1);
        fetch(32'h1FC);
        check("f1fc_fault", 32'(fault_a), 32'd0);
        check("f1fc_instr", instr_a, NOP);

        // Full-depth load without LoadLast (both instances)
        LoadStart = 1'b1;
        step();
        LoadStart = 1'b0;
        check("ls_ready", 32'(ready_a), 32'd0);
        check("ls_count", 32'(count_a), 32'd0);
        check("ls_valid", 32'(valid_a), 32'd0);
        for (int i = 0; i < 128; i++) begin
            load_word(32'hA500_0000 + 32'(i), 1'b0);
            if (i == 126) begin
                check("w126_ready", 32'(ready_a), 32'd0);
                check("w126_count", 32'(count_a), 32'd127);
            end
        end
        check("full_ready", 32'(ready_a), 32'd1);
        check("full_count", 32'(count_a), 32'd128);
        load_word(32'hDEAD_BEEF, 1'b0);
        check("extra_count", 32'(count_a), 32'd128);
        fetch(32'h0);
        check("word0_kept", instr_a, 32'hA500_0000);
        fetch(32'h1FC);
        check("word127", instr_a, 32'hA500_007F);

        // LoadStart with same-cycle ReadEn in RUN
        Address   = 32'h10;
        ReadEn    = 1'b1;
        LoadStart = 1'b1;
        step();
        LoadStart = 1'b0;
        ReadEn    = 1'b0;
        check("lsrd_valid", 32'(valid_a), 32'd0);
        check("lsrd_ready", 32'(ready_a), 32'd0);
        check("lsrd_count", 32'(count_a), 32'd0);
        check("lsrd_instr", instr_a, NOP);
        load_word(32'h1111_1111, 1'b0);
        load_word(32'h2222_2222, 1'b0);
        check("mid_count", 32'(count_b), 32'd2);

        // Reset abandons the load; written words stay
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("rstmid_ready_b", 32'(ready_b), 32'd1);
        check("rstmid_ready_a", 32'(ready_a), 32'd0);
        check("rstmid_count_b", 32'(count_b), 32'd0);
        fetch(32'h0);
        check("kept_w0", instr_b, 32'h1111_1111);
        fetch(32'h4);
        check("kept_w1", instr_b, 32'h2222_2222);
        fetch(32'h8);
        check("kept_w2", instr_b, 32'hA500_0002);

        // LoadStart overrides LoadLast inside LOAD (dut only is in LOAD)
        LoadStart = 1'b1;
        load_word(32'h3333_3333, 1'b1);
        LoadStart = 1'b0;
        check("lsll_ready", 32'(ready_a), 32'd0);
        check("lsll_count", 32'(count_a), 32'd1);
        load_word(32'h4444_4444, 1'b1);
        check("ll_ready", 32'(ready_a), 32'd1);
        check("ll_count", 32'(count_a), 32'd2);
        fetch(32'h0);
        check("ll_w0", instr_a, 32'h3333_3333);
        fetch(32'h4);
        check("ll_w1", instr_a, 32'h4444_4444);

        // Parity on dut0 (in RUN again, mem[2..3] from the full load)
        check("prep_ready_b", 32'(ready_b), 32'd1);
`ifdef IMEM_PARITY_EN
        dut0.mem[3][0] = ~dut0.mem[3][0];
        fetch(32'hC);
        check("par_err", 32'(perr_b), 32'd1);
        check("par_instr", instr_b, NOP);
        check("par_valid", 32'(valid_b), 32'd1);
        check("par_fault", 32'(fault_b), 32'd0);
        Stall = 1'b1;
        step();
        Stall = 1'b0;
        check("par_hold", 32'(perr_b), 32'd1);
`else
        fetch(32'hC);
        check("nopar_err", 32'(perr_b), 32'd0);
        check("nopar_instr", instr_b, 32'hA500_0003);
`endif
        fetch(32'h8);
        check("par_clean", 32'(perr_b), 32'd0);
        check("par_clean_instr", instr_b, 32'hA500_0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_memory_sync.md
Name: instruction_memory_sync

Overview:
- Parametrised, synchronous-read instruction memory for the MIPS datapath fetch stage.
- Generalises the fixed 128-word combinational ROM:
  - parametrised width and depth;
  - registered output with a valid flag and stall hold;
  - a sequential program-load port, so new programs load without re-synthesis;
  - address-fault detection.
- Sits between the PC register and the IF/ID pipeline register.

Parameters:
DATA_WIDTH, 32, instruction word width in bits
ADDR_BITS, 7, word-index bits; DEPTH = 2**ADDR_BITS words
LOAD_ON_RESET, 0, 1 = enter LOAD state after reset; 0 = enter RUN
NOP_WORD, 32'h00000000, word driven on fault/parity error (sll $0,$0,0)

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
Address  input  32  byte address from PC
ReadEn  input  1  fetch request
Stall  input  1  hold current output (pipeline stall)
LoadStart  input  1  enter LOAD state, clear load pointer
LoadValid  input  1  LoadData valid this cycle
LoadLast  input  1  final word of program (qualified by LoadValid)
LoadData  input  DATA_WIDTH  program word to write
Ready  output  1  high in RUN state
Instruction  output  DATA_WIDTH  registered instruction
InstrValid  output  1  Instruction is fresh this cycle
AddrFault  output  1  last fetch was misaligned or out of range
LoadCount  output  ADDR_BITS+1  words written in current load
ParityErr  output  1  parity mismatch on last fetch (see optional feature)

Behaviour:
- Reset (Clk edge with Reset=1) sets these values:
  - state = LOAD if LOAD_ON_RESET else RUN;
  - Instruction = NOP_WORD;
  - InstrValid = 0, AddrFault = 0, ParityErr = 0;
  - LoadCount = 0; load pointer = 0.
- Array contents are NOT cleared by Reset. They are initialised to NOP_WORD at time zero.
- States: LOAD, RUN.
- LOAD state:
  - Ready = 0. ReadEn and Stall are ignored. InstrValid = 0.
  - Each cycle with LoadValid=1: mem[ptr] <= LoadData, ptr++, LoadCount++.
  - LoadValid & LoadLast: write, then go to RUN next cycle.
  - Write to index DEPTH-1: write, then go to RUN regardless of LoadLast. No wrap, no overwrite of word 0.
  - LoadStart in LOAD: ptr and LoadCount reset to 0. A same-cycle LoadValid write goes to index 0, and ptr becomes 1.
- RUN state:
  - Ready = 1. Word index = Address[ADDR_BITS+1:2].
  - Fault = Address[1:0]!=0 OR Address[31:ADDR_BITS+2]!=0.
  - Stall=1 has priority: Instruction, InstrValid, AddrFault and ParityErr hold their values.
  - Stall=0 & ReadEn=1, no fault: Instruction <= mem[index], InstrValid <= 1, AddrFault <= 0.
  - Stall=0 & ReadEn=1, fault: Instruction <= NOP_WORD, InstrValid <= 1, AddrFault <= 1.
  - Stall=0 & ReadEn=0: InstrValid <= 0, AddrFault <= 0, Instruction holds.
  - Read latency: exactly 1 cycle from the Address/ReadEn edge.
  - LoadValid in RUN is ignored; no write occurs.
  - LoadStart in RUN: go to LOAD next cycle. ptr and LoadCount become 0, Instruction becomes NOP_WORD, InstrValid becomes 0. A same-cycle ReadEn is discarded.
- Simultaneous events:
  - Reset overrides everything.
  - LoadStart overrides LoadLast.
  - Reset during a load abandons it. Words already written remain.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each entry stores DATA_WIDTH+1 bits; the extra bit is even parity of LoadData, computed at write.
  - On a non-fault fetch with parity mismatch: Instruction <= NOP_WORD, ParityErr <= 1, InstrValid <= 1.
  - ParityErr follows the same hold/clear rules as AddrFault.
  - Time-zero contents carry correct parity.
- Undefined: no parity storage; ParityErr is tied to 0.

Test Plan:
1. LOAD_ON_RESET=1. Reset, then load 4 words 0x34040000, 0x08000004, 0x20040A0A, 0x8C900004 with LoadLast on the 4th -> Ready rises the cycle after the 4th write, LoadCount=4. Fetch Address=0x8 -> Instruction=0x20040A0A, InstrValid=1 one cycle later.
2. RUN. Fetch 0x4, then Stall=1 for 3 cycles while Address changes to 0xC -> Instruction stays 0x08000004 and InstrValid stays 1. Release Stall -> next cycle Instruction=0x8C900004.
3. ADDR_BITS=7. Fetch 0x202 -> AddrFault=1, Instruction=NOP_WORD. Fetch 0x200 (index 128) -> AddrFault=1. Fetch 0x1FC -> AddrFault=0.
4. Load without LoadLast until 128 words are written -> RUN is entered after word 127, LoadCount=128. A 129th LoadValid is ignored and word 0 is unchanged.
5. In RUN, assert LoadStart together with ReadEn -> no fetch occurs, InstrValid=0, Ready=0, LoadCount=0. Assert Reset mid-load after 2 words -> state=RUN (LOAD_ON_RESET=0) and both loaded words are readable.
6. IMEM_PARITY_EN: force a single bit flip in mem[3] via hierarchical write, fetch 0xC -> ParityErr=1, Instruction=NOP_WORD. Fetch 0x8 -> ParityErr=0.
